// File: rtl/axis_log_capture_pkg.sv
// axis_log_capture_pkg: shared constants for the log capture FIFO.
//   reset_type_e : reset style codes used across the codebase
//   CNT_W        : statistics counter width
//   flit_width() : width of one packed flit {TDATA, TKEEP, TDEST, TID, TLAST}
package axis_log_capture_pkg;

  typedef enum logic [1:0] {
    NO_RESET,
    ACTIVE_HIGH,
    ACTIVE_LOW
  } reset_type_e;

  localparam reset_type_e RESET_TYPE = ACTIVE_HIGH;
  localparam int unsigned CNT_W      = 32;

  function automatic int unsigned flit_width(input int unsigned data_width);
    return data_width + data_width / 8 + 3;
  endfunction

endpackage

// File: rtl/axis_log_capture_if.sv
// axis_log_capture_if: AXI Stream bundle for the log path.
//   master : drives TDATA/TVALID/TKEEP/TDEST/TID/TLAST, receives TREADY
//   slave  : receives payload/TVALID, drives TREADY
interface axis_log_capture_if #(
  parameter int unsigned DATA_WIDTH = 64
);

  logic [DATA_WIDTH-1:0]   TDATA;
  logic                    TVALID;
  logic                    TREADY;
  logic [DATA_WIDTH/8-1:0] TKEEP;
  logic                    TDEST;
  logic                    TID;
  logic                    TLAST;

  modport master (
    output TDATA, TVALID, TKEEP, TDEST, TID, TLAST,
    input  TREADY
  );

  modport slave (
    input  TDATA, TVALID, TKEEP, TDEST, TID, TLAST,
    output TREADY
  );

endinterface

// File: rtl/axis_log_capture_mem.sv
// axis_log_capture_mem: simple dual-port RAM holding packed flits.
//   clk          : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : asynchronous read port
module axis_log_capture_mem #(
  parameter int unsigned WIDTH  = 75,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_log_capture.sv
// axis_log_capture: first-word-fall-through FIFO between the stream governor's
// log output and the log consumer. in_TREADY and out_TVALID come straight from
// flops so the governor's combinational TVALID/TREADY dependency cannot loop.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : synchronous discard of all stored flits
//   in_axis    : log stream from governor (slave side)
//   out_axis   : buffered stream to consumer (master side)
//   occupancy  : stored flit count
//   flit_cnt   : accepted input flits
//   pkt_cnt    : accepted input flits with TLAST
// Optional: define AXIS_LOG_CAPTURE_STATS_EN to build flit_cnt/pkt_cnt;
// otherwise both outputs are tied to zero.
module axis_log_capture
  import axis_log_capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  axis_log_capture_if.slave    in_axis,
  axis_log_capture_if.master   out_axis,
  output logic [ADDR_W:0]      occupancy,
  output logic [CNT_W-1:0]     flit_cnt,
  output logic [CNT_W-1:0]     pkt_cnt
);

  localparam int unsigned     FLIT_W   = flit_width(DATA_WIDTH);
  localparam logic [ADDR_W:0] FULL_OCC = (ADDR_W+1)'(DEPTH);

  logic              full_r;
  logic              empty_r;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   occ_next;
  logic              push;
  logic              pop;
  logic [FLIT_W-1:0] wdata;
  logic [FLIT_W-1:0] rdata;

  assign in_axis.TREADY  = ~full_r;
  assign out_axis.TVALID = ~empty_r;

  assign push = in_axis.TVALID & ~full_r;
  assign pop  = ~empty_r & out_axis.TREADY;

  assign occ_next = occupancy + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);

  assign wdata = {in_axis.TDATA, in_axis.TKEEP, in_axis.TDEST, in_axis.TID, in_axis.TLAST};

  axis_log_capture_mem #(
    .WIDTH  (FLIT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Stale RAM contents are masked while empty so the outputs read zero after
  // reset without needing a resettable memory array.
  assign {out_axis.TDATA, out_axis.TKEEP, out_axis.TDEST, out_axis.TID, out_axis.TLAST} =
    empty_r ? '0 : rdata;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occupancy <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
    end else begin
      occupancy <= occ_next;
      full_r    <= (occ_next == FULL_OCC);
      empty_r   <= (occ_next == '0);
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
    end
  end

`ifdef AXIS_LOG_CAPTURE_STATS_EN
  // Counters see the raw handshake, so a flit accepted in a flush cycle is
  // still counted even though it is never stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (push)                  flit_cnt <= flit_cnt + CNT_W'(1);
      if (push && in_axis.TLAST) pkt_cnt  <= pkt_cnt + CNT_W'(1);
    end
  end
`else
  assign flit_cnt = '0;
  assign pkt_cnt  = '0;
`endif

endmodule

// File: tb/tb_axis_log_capture.sv
module tb_axis_log_capture;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] keep;
    logic            dest;
    logic            id;
    logic            last;
  } flit_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [4:0]  occupancy;
  logic [31:0] flit_cnt;
  logic [31:0] pkt_cnt;

  axis_log_capture_if #(.DATA_WIDTH(DW)) in_axis ();
  axis_log_capture_if #(.DATA_WIDTH(DW)) out_axis ();

  axis_log_capture #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_axis   (in_axis),
    .out_axis  (out_axis),
    .occupancy (occupancy),
    .flit_cnt  (flit_cnt),
    .pkt_cnt   (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of flits plus plain counters.
  flit_t       q[$];
  logic [31:0] m_flits;
  logic [31:0] m_pkts;
  bit          model_ok = 0;

  initial begin
    forever begin
      bit   m_push;
      bit   m_pop;
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_flits  = '0;
        m_pkts   = '0;
        model_ok = 1;
      end else if (model_ok) begin
        m_push = in_axis.TVALID && (q.size() < DEPTH);
        m_pop  = (q.size() > 0) && out_axis.TREADY;
        if (m_push) begin
          m_flits = m_flits + 1;
          if (in_axis.TLAST) m_pkts = m_pkts + 1;
        end
        if (flush) begin
          q.delete();
        end else begin
          if (m_pop) void'(q.pop_front());
          if (m_push) q.push_back({in_axis.TDATA, in_axis.TKEEP, in_axis.TDEST,
                                   in_axis.TID, in_axis.TLAST});
        end
      end
    end
  end

  // Compare process: every negedge once the model has seen reset.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("in_TREADY",  in_axis.TREADY,  q.size() < DEPTH);
        check("out_TVALID", out_axis.TVALID, q.size() > 0);
        check("occupancy",  occupancy,       q.size());
`ifdef AXIS_LOG_CAPTURE_STATS_EN
        check("flit_cnt",   flit_cnt,        m_flits);
        check("pkt_cnt",    pkt_cnt,         m_pkts);
`else
        check("flit_cnt",   flit_cnt,        0);
        check("pkt_cnt",    pkt_cnt,         0);
`endif
        if (q.size() > 0) begin
          check("out_TDATA", out_axis.TDATA, q[0].data);
          check("out_TKEEP", out_axis.TKEEP, q[0].keep);
          check("out_TDEST", out_axis.TDEST, q[0].dest);
          check("out_TID",   out_axis.TID,   q[0].id);
          check("out_TLAST", out_axis.TLAST, q[0].last);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [63:0] d, input bit l);
    in_axis.TVALID = v;
    in_axis.TDATA  = d;
    in_axis.TLAST  = l;
    in_axis.TKEEP  = 8'hFF;
    in_axis.TDEST  = 1'b0;
    in_axis.TID    = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    set_in(0, 0, 0);
    out_axis.TREADY = 1'b1;
    while (out_axis.TVALID && n < 64) begin
      step();
      n++;
    end
    check("drain_done", out_axis.TVALID, 0);
  endtask

  logic [31:0] exp_flits;
  logic [31:0] exp_pkts;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    set_in(0, 0, 0);
    out_axis.TREADY = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_in_TREADY",  in_axis.TREADY,  1);
    check("rst_out_TVALID", out_axis.TVALID, 0);
    check("rst_occupancy",  occupancy,       0);
    check("rst_flit_cnt",   flit_cnt,        0);
    check("rst_out_TDATA",  out_axis.TDATA,  0);
    step();
    step();

    // Single flit, visible one cycle after the push
    out_axis.TREADY = 1'b1;
    set_in(1, 64'hDEAD_BEEF, 1);
    step();
    set_in(0, 0, 0);
    check("single_valid", out_axis.TVALID, 1);
    check("single_data",  out_axis.TDATA,  64'hDEAD_BEEF);
    check("single_last",  out_axis.TLAST,  1);
    check("single_keep",  out_axis.TKEEP,  8'hFF);
    step();
    check("single_occ_after_pop", occupancy, 0);

    // Fill to DEPTH with consumer stalled
    out_axis.TREADY = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, 64'(i), 0);
      step();
    end
    check("full_ready", in_axis.TREADY, 0);
    check("full_occ",   occupancy,      16);
    set_in(1, 64'd99, 0);
    step();
    check("full_noadd_occ", occupancy, 16);
    check("full_head_hold", out_axis.TDATA, 0);
    set_in(0, 0, 0);
    out_axis.TREADY = 1'b1;
    step();
    out_axis.TREADY = 1'b0;
    check("pop_ready", in_axis.TREADY, 1);
    check("pop_occ",   occupancy,      15);
    check("pop_next",  out_axis.TDATA, 1);
    drain();

    // Streaming at occupancy 3
    out_axis.TREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 64'(100 + i), 0);
      step();
    end
    out_axis.TREADY = 1'b1;
    for (int i = 0; i < 100; i++) begin
      set_in(1, 64'(200 + i), 0);
      step();
      if (occupancy != 3) check("stream_occ", occupancy, 3);
    end
    check("stream_occ_end", occupancy, 3);
    drain();

    // Flush with occupancy 7 and a flit offered in the flush cycle
    out_axis.TREADY = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_in(1, 64'(300 + i), 0);
      step();
    end
    check("preflush_occ", occupancy, 7);
    set_in(1, 64'h777, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_in(0, 0, 0);
    check("flush_occ",   occupancy,       0);
    check("flush_valid", out_axis.TVALID, 0);
    check("flush_ready", in_axis.TREADY,  1);
    step();

`ifdef AXIS_LOG_CAPTURE_STATS_EN
    exp_flits = 32'd128;
    exp_pkts  = 32'd1;
`else
    exp_flits = 32'd0;
    exp_pkts  = 32'd0;
`endif
    check("lit_flit_cnt", flit_cnt, exp_flits);
    check("lit_pkt_cnt",  pkt_cnt,  exp_pkts);

    // Randomized traffic, alternating stall-heavy and drain-heavy phases
    for (int i = 0; i < 3000; i++) begin
      bit heavy_stall;
      heavy_stall = ((i / 400) % 2) == 0;
      in_axis.TVALID  = ($urandom % 4) != 0;
      in_axis.TDATA   = {$urandom, $urandom};
      in_axis.TKEEP   = 8'($urandom);
      in_axis.TDEST   = 1'($urandom);
      in_axis.TID     = 1'($urandom);
      in_axis.TLAST   = ($urandom % 5) == 0;
      out_axis.TREADY = heavy_stall ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      flush           = ($urandom % 97) == 0;
      step();
    end
    flush = 1'b0;
    drain();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_log_capture.md
Name: axis_log_capture

Overview:
- Buffers the log AXI Stream produced by the stream governor and presents it to the log consumer (host DMA / debug sink).
- Governor's log_TVALID depends combinationally on log_TREADY, so this block guarantees in_TREADY is driven purely from registered state, never from in_TVALID.
- Synchronous FIFO with registered full/empty, flush control and optional flit/packet statistics.

Parameters:
- DATA_WIDTH, 64, TDATA width in bits; TKEEP is DATA_WIDTH/8.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; occupancy counter is ADDR_W+1 bits.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous flush; discards all stored flits.
- in_TDATA  in  DATA_WIDTH  log data from governor.
- in_TVALID  in  1  log valid.
- in_TREADY  out  1  registered; high iff FIFO not full.
- in_TKEEP  in  DATA_WIDTH/8  byte enables.
- in_TDEST  in  1  dest bit.
- in_TID  in  1  id bit.
- in_TLAST  in  1  end of packet.
- out_TDATA  out  DATA_WIDTH  buffered data.
- out_TVALID  out  1  high iff FIFO not empty.
- out_TREADY  in  1  consumer ready.
- out_TKEEP  out  DATA_WIDTH/8.
- out_TDEST  out  1.
- out_TID  out  1.
- out_TLAST  out  1.
- occupancy  out  ADDR_W+1  stored flit count.
- flit_cnt  out  32  accepted input flits (statistics).
- pkt_cnt  out  32  accepted input TLAST flits (statistics).

Behaviour:
- Reset (rst=1 at clk edge): occupancy=0, pointers=0, in_TREADY=1 on the first cycle after reset, out_TVALID=0, counters=0, out_* data=0. Reset wins over everything.
- push = in_TVALID & in_TREADY. pop = out_TVALID & out_TREADY.
- in_TREADY and out_TVALID are flop outputs:
  - full_r <= (occ_next == DEPTH).
  - empty_r <= (occ_next == 0).
  - in_TREADY = ~full_r; out_TVALID = ~empty_r.
- occ_next = occupancy + push - pop.
- Latency: flit pushed at cycle N into an empty FIFO is valid on out at cycle N+1. Output fields come from the entry at the read pointer; first-word-fall-through, no extra bubble.
- Simultaneous push and pop at any occupancy 1..DEPTH-1: occupancy unchanged, both pointers advance.
- When full: push impossible; pop alone frees one slot and in_TREADY=1 next cycle.
- When empty: pop impossible; push alone gives out_TVALID=1 next cycle.
- Pointers wrap modulo DEPTH.
- Output stability: while out_TVALID=1 and out_TREADY=0, all out_* fields hold.
- Flit fields (TDATA, TKEEP, TDEST, TID, TLAST) are stored as one entry.
- flush=1 at an edge:
  - Occupancy and pointers go to 0, out_TVALID=0 and in_TREADY=1 next cycle.
  - A push or pop in the flush cycle is discarded.
  - Statistic counters are not cleared.
- Counters:
  - flit_cnt += push; pkt_cnt += (push & in_TLAST).
  - 32-bit, wrap from 0xFFFFFFFF to 0.
  - Cleared only by rst.

Optional Feature:
- Macro: AXIS_LOG_CAPTURE_STATS_EN.
- Defined: flit_cnt and pkt_cnt counters are implemented as specified.
- Undefined: counters are not built, flit_cnt and pkt_cnt are tied to 0, and the port list is unchanged.
- occupancy is always present.

Decomposition:
- Shared package/include: RESET_TYPE codes (NO_RESET, ACTIVE_HIGH, ACTIVE_LOW), the flit field-packing width DATA_WIDTH + DATA_WIDTH/8 + 3, and the counter width constant 32.
- Natural sub-module: axis_log_capture_mem, a simple dual-port RAM (one write port, asynchronous read at the read pointer) holding packed flits.
- Control, flags and counters stay in the top module.

Test Plan:
- Reset then idle: after rst, in_TREADY=1, out_TVALID=0, occupancy=0, flit_cnt=0.
- Single flit 0xDEAD_BEEF with TLAST=1, TKEEP=0xFF at cycle 5, out_TREADY=1: out shows 0xDEAD_BEEF with TLAST=1 at cycle 6; flit_cnt=1, pkt_cnt=1.
- Fill DEPTH=16 with out_TREADY=0 and data 0..15: in_TREADY=0 the cycle after the 16th push, occupancy=16. One pop returns 0; in_TREADY=1 next cycle.
- Simultaneous push/pop streaming 100 flits at occupancy 3 with both sides always ready: occupancy stays 3 and output order matches input.
- flush asserted with occupancy=7 while in_TVALID=1: next cycle occupancy=0, out_TVALID=0, in_TREADY=1. The flushed-cycle flit is absent from out and counted in flit_cnt.
- Compiled without AXIS_LOG_CAPTURE_STATS_EN, after 20 pushes: flit_cnt=0 and pkt_cnt=0, while data path behaviour is identical.
